spi_word_rx: RTL
================

# spi_word_rx

Serial front end for the configuration path. It frames the host serial stream with `cs_n` and deserializes `sdi` into parallel words. For each complete word it presents `din_word` together with a one-cycle `lclk` load strobe to the configuration register block, which captures on the falling edge of the same `sclk`. It also shifts a parallel status/readback word out on `sdo`, and reports per-frame word count and framing errors.

## Interface
- `WORD_W`, default 8: serial word width; legal range 2..16.
- `MSB_FIRST`, default 1: 1 = first serial bit is word MSB; 0 = first bit is LSB (applies to both `sdi` and `sdo`).
- `CNT_W`, default 8: width of the per-frame word counter.

- `sclk`  in  1: serial clock, the only clock. All logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cs_n`  in  1: frame select, active low, sampled on `sclk` rising edge.
- `sdi`  in  1: serial data in, sampled on the rising edge while `cs_n`=0.
- `tx_word`  in  WORD_W: readback word, loaded at each word boundary.
- `sdo`  out  WORD_W→1: serial data out. Forced to 0 while `cs_n`=1.
- `din_word`  out  WORD_W: last completed word, held until the next word completes.
- `lclk`  out  1: load strobe, high for exactly one cycle per completed word.
- `word_cnt`  out  CNT_W: completed words in the current frame, saturating.
- `frame_err`  out  1: sticky flag; the previous frame ended mid-word.
- `busy`  out  1: high while in SHIFT.

## Operation
- Two states: IDLE and SHIFT. `bit_cnt` counts 0..WORD_W-1; `rx_sh` is a WORD_W-1 bit receive shift register; `tx_sh` is a WORD_W bit transmit shift register.
- IDLE, `cs_n`=1: `bit_cnt`=0 and `tx_sh` is loaded with `tx_word` on every edge.
- IDLE, `cs_n`=0 at an edge (frame start):
  - sample `sdi` as bit 0 and set `bit_cnt`=1;
  - clear `word_cnt` and `frame_err`;
  - shift `tx_sh` by one;
  - go to SHIFT.
- SHIFT, `cs_n`=0 at an edge: sample `sdi`, shift `tx_sh`, increment `bit_cnt`.
  - When the sampled bit is bit WORD_W-1:
    - `din_word` <= assembled word (earlier bits plus the current `sdi`);
    - `lclk` <= 1;
    - `word_cnt` <= `word_cnt`+1, saturating at 2^CNT_W-1;
    - `bit_cnt` <= 0;
    - `tx_sh` <= `tx_word` (reload);
    - stay in SHIFT.
  - The next word's bit 0 may follow on the very next edge. Back-to-back words need no gap.
- SHIFT, `cs_n`=1 at an edge: go to IDLE.
  - If `bit_cnt`≠0, discard the partial word (no `lclk`, `din_word` unchanged) and set `frame_err`=1.
  - If `bit_cnt`=0, the frame ended cleanly; `frame_err` is unchanged.
- Bit order:
  - MSB_FIRST=1: `rx_sh` shifts left with `sdi` entering the LSB; `sdo` = `tx_sh[WORD_W-1]`.
  - MSB_FIRST=0: mirror image; `sdi` enters the MSB and `sdo` = `tx_sh[0]`.
- `lclk` is registered. It is cleared on every edge that does not complete a word.
- `word_cnt` and `frame_err` hold their values in IDLE until the next frame start.

## Timing
- Reset values:
  - state = IDLE, `bit_cnt`=0, `rx_sh`=0, `tx_sh`=0;
  - `din_word`=0, `lclk`=0, `word_cnt`=0, `frame_err`=0, `busy`=0;
  - `sdo`=0.
- Reset mid-word: all state clears immediately (asynchronously) and the partial word is lost without setting `frame_err`. After `rst_n` is released with `cs_n` low, the first edge is treated as a frame start.
- Latency: `din_word` and `lclk` become valid in the cycle that starts at the rising edge sampling the last bit. The downstream falling-edge capture lands half a cycle later, while both are stable.
- Spacing: consecutive `lclk` pulses are exactly WORD_W cycles apart in a continuous frame.
- `sdo`: the first bit is valid as soon as `cs_n` falls, because `tx_sh` is preloaded in IDLE. Each following bit changes on the rising edge after the previous bit was sampled. The host samples `sdo` on the falling edge.
- Simultaneous events:
  - the edge that completes a word while `cs_n`=0 always produces `lclk`;
  - if `cs_n` rises exactly at a word boundary (`bit_cnt`=0), no error is flagged;
  - `word_cnt` saturation does not suppress `lclk`.

## Test plan
- Single byte, MSB_FIRST=1: `cs_n` low, `sdi` = 0x03 serially MSB first, then `cs_n` high → `din_word`=0x03, one `lclk` pulse in the cycle after the 8th edge, `word_cnt`=1, `frame_err`=0, `busy` falls one edge after `cs_n` rises.
- Continuous frame: command 0x03 followed by 24 data bytes 0x00..0x17 with no gaps → 25 `lclk` pulses exactly 8 cycles apart, each `din_word` matching its byte, `word_cnt`=25.
- Aborted word: 5 bits of 0xFF, then `cs_n` high → no `lclk`, `din_word` keeps its previous value, `frame_err`=1. The next frame sending 0xA5 clears `frame_err` at its first edge and yields `din_word`=0xA5.
- Readback: `tx_word`=0x5A, two-byte frame → `sdo` sequence 0,1,0,1,1,0,1,0, then the second byte again equals the current `tx_word`. `sdo`=0 whenever `cs_n`=1.
- Reset mid-word: assert `rst_n`=0 after 4 bits → all outputs 0 immediately. After release, a clean byte 0x09 decodes correctly with `word_cnt`=1.
- MSB_FIRST=0 and `CNT_W`=2: send 0x01 LSB first five times → every `din_word`=0x01, and `word_cnt` saturates at 3 while `lclk` still pulses five times.

Source files
------------

// File: rtl/spi_word_rx.sv
// Serial-to-word receiver with readback shifter; din_word/lclk valid the cycle after the last bit edge.
// No backpressure: one word per WORD_W sclk edges, lclk pulses even when word_cnt saturates.
module spi_word_rx #(
  parameter int WORD_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              sdi,
  input  logic [WORD_W-1:0] tx_word,
  output logic              sdo,
  output logic [WORD_W-1:0] din_word,
  output logic              lclk,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              frame_err,
  output logic              busy
);
  localparam int BW = $clog2(WORD_W);
  localparam logic [BW-1:0] LAST = BW'(WORD_W - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-2:0] rx_sh_q, rx_sh_d, rx_sh_next;
  logic [WORD_W-1:0] tx_sh_q, tx_sh_d, tx_shifted;
  logic [WORD_W-1:0] din_q, din_d, rx_word;
  logic              lclk_q, lclk_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              word_done;

  // Bit-order dependent views: the full word including the bit on sdi now, and the shifted registers.
  always_comb begin
    if (MSB_FIRST) begin
      rx_word    = {rx_sh_q, sdi};
      rx_sh_next = rx_word[WORD_W-2:0];
      tx_shifted = {tx_sh_q[WORD_W-2:0], 1'b0};
    end else begin
      rx_word    = {sdi, rx_sh_q};
      rx_sh_next = rx_word[WORD_W-1:1];
      tx_shifted = {1'b0, tx_sh_q[WORD_W-1:1]};
    end
  end

  assign word_done = (state_q == SHIFT) && !cs_n && (bit_cnt_q == LAST);

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (!cs_n) state_d = SHIFT;
    end else begin
      if (cs_n) state_d = IDLE;
    end
  end

  always_comb begin
    busy = (state_q == SHIFT);
    sdo  = !cs_n && (MSB_FIRST ? tx_sh_q[WORD_W-1] : tx_sh_q[0]);
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_sh_d   = rx_sh_q;
    tx_sh_d   = tx_sh_q;
    din_d     = din_q;
    lclk_d    = 1'b0;
    cnt_d     = cnt_q;
    err_d     = err_q;
    if (cs_n) begin
      bit_cnt_d = '0;
      if (state_q == IDLE) begin
        tx_sh_d = tx_word;
      end else if (bit_cnt_q != '0) begin
        err_d = 1'b1;
      end
    end else begin
      rx_sh_d   = rx_sh_next;
      tx_sh_d   = tx_shifted;
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (state_q == IDLE) begin
        cnt_d     = '0;
        err_d     = 1'b0;
        bit_cnt_d = BW'(1);
      end
      if (word_done) begin
        din_d     = rx_word;
        lclk_d    = 1'b1;
        bit_cnt_d = '0;
        tx_sh_d   = tx_word;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      rx_sh_q   <= '0;
      tx_sh_q   <= '0;
      din_q     <= '0;
      lclk_q    <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      rx_sh_q   <= rx_sh_d;
      tx_sh_q   <= tx_sh_d;
      din_q     <= din_d;
      lclk_q    <= lclk_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign din_word  = din_q;
  assign lclk      = lclk_q;
  assign word_cnt  = cnt_q;
  assign frame_err = err_q;

endmodule
